// File: rtl/fmul_72bit_pkg.sv
// Shared constants and state encoding for the 72-bit floating-point multiplier.
// Operand format is {sign, exp[10:0], fract[59:0]} with an exponent bias of 1023.
package fmul_72bit_pkg;

    localparam int EXP_W     = 11;
    localparam int FRACT_W   = 60;
    localparam int MANT_W    = 61;
    localparam int PROD_W    = 122;
    localparam int EXP_SUM_W = 13;
    localparam logic [EXP_SUM_W-1:0] BIAS = 13'd1023;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of multiplier digits needed to cover a 61-bit mantissa.
    function automatic int iter_count(input int digit_w);
        return (MANT_W + digit_w - 1) / digit_w;
    endfunction

endpackage

// File: rtl/fmul_72bit_iter_mac.sv
// Digit-serial mantissa multiplier slice.
// Retires DIGIT_W multiplier bits per step, LSB first, into a right-shifting hi/lo accumulator.
module fmul_72bit_iter_mac
    import fmul_72bit_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] mcand,
    input  logic [MANT_W-1:0] mplier,
    output logic [PROD_W-1:0] product_next
);

    localparam int ITER  = iter_count(DIGIT_W);
    localparam int PAD_W = ITER * DIGIT_W;
    localparam int PP_W  = MANT_W + DIGIT_W;
    localparam int FULL_W = MANT_W + PAD_W;

    logic [MANT_W-1:0] mcand_reg;
    logic [PAD_W-1:0]  mplier_reg;
    logic [MANT_W-1:0] hi_reg;
    logic [PAD_W-1:0]  lo_reg;

    logic [DIGIT_W-1:0] digit;
    logic [PP_W-1:0]    pp;
    logic [PP_W-1:0]    sum;
    logic [MANT_W-1:0]  hi_next;
    logic [PAD_W-1:0]   lo_next;
    logic [FULL_W-1:0]  full_next;

    assign digit = mplier_reg[DIGIT_W-1:0];
    assign pp    = PP_W'(mcand_reg) * PP_W'(digit);
    // hi_reg < 2^61, so hi + mcand*digit always fits in MANT_W+DIGIT_W bits.
    assign sum     = pp + PP_W'(hi_reg);
    assign hi_next = sum[PP_W-1:DIGIT_W];
    assign lo_next = {sum[DIGIT_W-1:0], lo_reg[PAD_W-1:DIGIT_W]};
    assign full_next = {hi_next, lo_next};
    assign product_next = full_next[PROD_W-1:0];

    // Bits above 122 only exist when the multiplier is zero-padded; they are always zero.
    generate
        if (FULL_W > PROD_W) begin : g_trim
            logic unused_top;
            assign unused_top = |full_next[FULL_W-1:PROD_W];
        end
    endgenerate

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (load) begin
            mcand_reg  <= mcand;
            mplier_reg <= PAD_W'(mplier);
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (step) begin
            mplier_reg <= mplier_reg >> DIGIT_W;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

endmodule

// File: rtl/fmul_72bit_mantissa_mul_iter.sv
// Unpack-and-multiply stage: captures sign, exponent sum and exception flags,
// runs the digit-serial mantissa multiply and hands the exact product downstream.
module fmul_72bit_mantissa_mul_iter
    import fmul_72bit_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iDATA_VALID,
    output logic                 oDATA_BUSY,
    input  logic [71:0]          iDATA_A,
    input  logic [71:0]          iDATA_B,
    output logic                 oDATA_VALID,
    input  logic                 iDATA_BUSY,
    output logic                 oDATA_SIGN,
    output logic [EXP_SUM_W-1:0] oDATA_EXP,
    output logic [PROD_W-1:0]    oDATA_FRACT,
    output logic                 oDATA_EXCEPT_EXP_A0,
    output logic                 oDATA_EXCEPT_EXP_B0,
    output logic                 oDATA_EXCEPT_EXP_A1,
    output logic                 oDATA_EXCEPT_EXP_B1,
    output logic                 oDATA_EXCEPT_FRACT_A0,
    output logic                 oDATA_EXCEPT_FRACT_B0
);

    localparam int ITER = iter_count(DIGIT_W);
    localparam logic [6:0] LAST_CNT = 7'(ITER - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] MUL  = ST_MUL;
    localparam logic [1:0] DONE = ST_DONE;

    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [FRACT_W-1:0] fract_a, fract_b;
    logic [MANT_W-1:0]  mant_a, mant_b;
    logic [EXP_SUM_W-1:0] exp_sum;
    logic [5:0]         flags_in;

    assign exp_a   = iDATA_A[70:60];
    assign exp_b   = iDATA_B[70:60];
    assign fract_a = iDATA_A[59:0];
    assign fract_b = iDATA_B[59:0];
    assign mant_a  = {exp_a != '0, fract_a};
    assign mant_b  = {exp_b != '0, fract_b};
    assign exp_sum = EXP_SUM_W'(exp_a) + EXP_SUM_W'(exp_b) - BIAS;
    assign flags_in = {exp_a == '0, exp_b == '0, exp_a == '1, exp_b == '1,
                       fract_a == '0, fract_b == '0};

    logic [1:0]           state_reg;
    logic [6:0]           cnt_reg;
    logic                 sign_reg;
    logic [EXP_SUM_W-1:0] exp_sum_reg;
    logic [5:0]           flags_reg;

    logic                 valid_reg;
    logic                 out_sign_reg;
    logic [EXP_SUM_W-1:0] out_exp_reg;
    logic [PROD_W-1:0]    out_fract_reg;
    logic [5:0]           out_flags_reg;

    logic                 accept;
    logic                 mac_step;
    logic [PROD_W-1:0]    product_next;

    assign accept   = (state_reg == IDLE) && iDATA_VALID;
    assign mac_step = (state_reg == MUL);

    fmul_72bit_iter_mac #(
        .DIGIT_W(DIGIT_W)
    ) u_mac (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .load         (accept),
        .step         (mac_step),
        .mcand        (mant_a),
        .mplier       (mant_b),
        .product_next (product_next)
    );

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sign_reg      <= 1'b0;
            exp_sum_reg   <= '0;
            flags_reg     <= '0;
            valid_reg     <= 1'b0;
            out_sign_reg  <= 1'b0;
            out_exp_reg   <= '0;
            out_fract_reg <= '0;
            out_flags_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (iDATA_VALID) begin
                        sign_reg    <= iDATA_A[71] ^ iDATA_B[71];
                        exp_sum_reg <= exp_sum;
                        flags_reg   <= flags_in;
                        cnt_reg     <= '0;
                        state_reg   <= MUL;
                    end
                end
                MUL: begin
                    cnt_reg <= cnt_reg + 7'd1;
                    // The last digit is still in flight, so take the product from the MAC's next value.
                    if (cnt_reg == LAST_CNT) begin
                        out_sign_reg  <= sign_reg;
                        out_exp_reg   <= exp_sum_reg;
                        out_fract_reg <= product_next;
                        out_flags_reg <= flags_reg;
                        valid_reg     <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (!iDATA_BUSY) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign oDATA_BUSY            = (state_reg != IDLE);
    assign oDATA_VALID           = valid_reg;
    assign oDATA_SIGN            = out_sign_reg;
    assign oDATA_EXP             = out_exp_reg;
    assign oDATA_FRACT           = out_fract_reg;
    assign oDATA_EXCEPT_EXP_A0   = out_flags_reg[5];
    assign oDATA_EXCEPT_EXP_B0   = out_flags_reg[4];
    assign oDATA_EXCEPT_EXP_A1   = out_flags_reg[3];
    assign oDATA_EXCEPT_EXP_B1   = out_flags_reg[2];
    assign oDATA_EXCEPT_FRACT_A0 = out_flags_reg[1];
    assign oDATA_EXCEPT_FRACT_B0 = out_flags_reg[0];

endmodule
